// File: rtl/calc_pkg.sv
// Shared calculator definitions: arithmetic-unit FSM states and default datapath width.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// 2*WIDTH-bit product and upper-half overflow flag returned on a valid/ready handshake.
module shift_add_multiplier
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [CNT_W-1:0]     r_count;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_overflow;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;

  // Adder carry lands in the accumulator MSB as the whole register shifts right.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= multiplicand;
            r_acc      <= {{WIDTH{1'b0}}, multiplier};
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CNT_W'(1);
          // Outputs load from the final accumulator value so they are valid on DONE entry.
          if (r_count == LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_product   <= w_acc_next;
            r_overflow  <= |w_acc_next[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       in_valid,  in_ready,  out_valid,  out_ready,  overflow;
  logic [3:0] a4, b4;
  logic [7:0] product;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, overflow8;
  logic [7:0] a8, b8;
  logic [15:0] product8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [8:0]  exp_q  [$];
  logic [16:0] exp8_q [$];

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(a4), .multiplier(b4), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .overflow(overflow)
  );

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .multiplicand(a8), .multiplier(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8), .overflow(overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operand pair, hold the result for 'hold' cycles, then hand it off.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int hold);
    int unsigned lat;
    logic [8:0]  e;
    logic [7:0]  prod_exp;
    check("accept_ready", 32'(in_ready), 32'd1);
    prod_exp = 8'(a) * 8'(b);
    in_valid = 1'b1; a4 = a; b4 = b;
    exp_q.push_back({prod_exp > 8'd15, prod_exp});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    check($sformatf("latency %0d*%0d", a, b), lat, 32'd4);
    check("sb_nonempty", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check($sformatf("product %0d*%0d", a, b), 32'(product), 32'(e[7:0]));
    check($sformatf("overflow %0d*%0d", a, b), 32'(overflow), 32'(e[8]));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_product",  32'(product),   32'(e[7:0]));
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid",  32'(out_valid), 32'd0);
    check("handoff_ready",  32'(in_ready),  32'd1);
    check("retain_product", 32'(product),   32'(e[7:0]));
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
    int unsigned lat;
    logic [16:0] e;
    logic [15:0] prod_exp;
    check("accept_ready8", 32'(in_ready8), 32'd1);
    prod_exp = 16'(a) * 16'(b);
    in_valid8 = 1'b1; a8 = a; b8 = b;
    exp8_q.push_back({prod_exp > 16'd255, prod_exp});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid8 && lat < 30);
    check("latency8", lat, 32'd8);
    if (exp8_q.size() == 0) begin
      check("sb8_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp8_q.pop_front();
    check($sformatf("product8 %0d*%0d", a, b), 32'(product8), 32'(e[15:0]));
    check("overflow8", 32'(overflow8), 32'(e[16]));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("handoff_valid8", 32'(out_valid8), 32'd0);
  endtask

  initial begin
    int unsigned seen;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a4 = '0; b4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product",   32'(product),   32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(4'd3,  4'd5,  0);
    do_op(4'd15, 4'd15, 0);
    do_op(4'd4,  4'd4,  0);
    do_op(4'd0,  4'd9,  0);
    do_op(4'd9,  4'd0,  0);
    do_op(4'd3,  4'd5,  5);

    // Abort after two iterations with an asynchronous reset between edges.
    in_valid = 1'b1; a4 = 4'd10; b4 = 4'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product",   32'(product),   32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_overflow",  32'(overflow),  32'd0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 32'd0);
    do_op(4'd7, 4'd6, 0);

    for (int unsigned ia = 0; ia < 16; ia++)
      for (int unsigned ib = 0; ib < 16; ib++)
        do_op(4'(ia), 4'(ib), 0);

    do_op8(8'd255, 8'd255);
    do_op8(8'd0,   8'd200);
    for (int i = 0; i < 1000; i++)
      do_op8(8'($urandom), 8'($urandom));

    check("sb_drained",  32'(exp_q.size()),  32'd0);
    check("sb8_drained", 32'(exp8_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
